encoder_scan: RTL

//  Parametrised, registered successor to the fixed 8-to-3 priority encoder.
//  - Captures a WIDTH-bit request vector.
//  - Emits the index of every set bit, one per handshake beat, highest index first.
//  - Sits between request sources (interrupt lines, key matrices) and a consumer that services one index at a time.

---
 rtl/encoder_scan.sv | 108 ++++++++++
 1 files changed

// File: rtl/encoder_scan.sv
// Registered request scanner: captures a request vector and emits one set-bit index per beat.
// Define SCAN_LSB_FIRST_EN to scan lowest index first (default: highest index first).
module encoder_scan #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic [WIDTH-1:0] iData,
    input  logic             iLoad,
    output logic             oReady,
    output logic [IDX_W-1:0] oData,
    output logic             oValid,
    input  logic             iAck,
    output logic             oLast,
    output logic             oNone
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             none_q, none_d;

    // Later matches overwrite earlier ones, so loop direction sets the priority.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
`ifdef SCAN_LSB_FIRST_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            none_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            last_q   <= last_d;
            none_q   <= none_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        none_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iLoad) begin
                    if (iData != '0) begin
                        shadow_d = iData;
                        state_d  = StScan;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (iAck) begin
                    if (last_q) begin
                        shadow_d = '0;
                        state_d  = StIdle;
                    end else begin
                        shadow_d = shadow_q & ~(WIDTH'(1) << data_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are precomputed from the next shadow so the next index shows without a bubble.
        if (state_d == StScan) begin
            data_d = pick_idx(shadow_d);
            last_d = single_bit(shadow_d);
        end else begin
            data_d = data_q;
            last_d = 1'b0;
        end
    end

    always_comb begin
        oReady = (state_q == StIdle);
        oValid = (state_q == StScan);
        oData  = data_q;
        oLast  = last_q;
        oNone  = none_q;
    end

endmodule
